// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants. The register-file word multiplexor wrapper
// and its per-bit slices both size themselves from these values.
package cpu_pkg;

  localparam int unsigned NUM_INPUTS = 32;
  localparam int unsigned SEL_W      = 5;

endpackage : cpu_pkg

// File: rtl/mux2_1.sv
// mux2_1: single-bit 2:1 select stage used as a node of the select tree.
// Ports:
//   a   - input selected when s = 0 (even / lower index)
//   b   - input selected when s = 1 (odd / upper index)
//   s   - select
//   out - combinational result
module mux2_1 (
  output logic out,
  input  logic a,
  input  logic b,
  input  logic s
);

  assign out = s ? b : a;

endmodule : mux2_1

// File: rtl/mux32_1.sv
// mux32_1: registered 32-to-1 single-bit multiplexer, one bit slice of the
// register-file read-port word multiplexor (64 copies share one select).
// Ports:
//   clk     - clock, all state updates on the rising edge
//   reset_n - synchronous active-low reset, clears out
//   in      - 32 data bits, in[k] comes from source k
//   control - 5-bit select index, 0 picks in[0], 31 picks in[31]
//   out     - registered selected bit, one cycle latency
module mux32_1
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] in,
  input  logic [SEL_W-1:0]      control,
  output logic                  out
);

  localparam int unsigned L0_N = NUM_INPUTS / 2;
  localparam int unsigned L1_N = L0_N / 2;
  localparam int unsigned L2_N = L1_N / 2;
  localparam int unsigned L3_N = L2_N / 2;

  logic [L0_N-1:0] lvl0;
  logic [L1_N-1:0] lvl1;
  logic [L2_N-1:0] lvl2;
  logic [L3_N-1:0] lvl3;
  logic            sel;
  logic            out_d;
  logic            out_q;

  // Level 0: pair adjacent inputs on control[0]
  for (genvar i = 0; i < L0_N; i++) begin : g_lvl0
    mux2_1 u_mux (.out(lvl0[i]), .a(in[2*i]), .b(in[2*i+1]), .s(control[0]));
  end

  // Level 1: control[1]
  for (genvar i = 0; i < L1_N; i++) begin : g_lvl1
    mux2_1 u_mux (.out(lvl1[i]), .a(lvl0[2*i]), .b(lvl0[2*i+1]), .s(control[1]));
  end

  // Level 2: control[2]
  for (genvar i = 0; i < L2_N; i++) begin : g_lvl2
    mux2_1 u_mux (.out(lvl2[i]), .a(lvl1[2*i]), .b(lvl1[2*i+1]), .s(control[2]));
  end

  // Level 3: control[3]
  for (genvar i = 0; i < L3_N; i++) begin : g_lvl3
    mux2_1 u_mux (.out(lvl3[i]), .a(lvl2[2*i]), .b(lvl2[2*i+1]), .s(control[3]));
  end

  // Level 4: root node on control[4]
  mux2_1 u_root (.out(sel), .a(lvl3[0]), .b(lvl3[1]), .s(control[4]));

  assign out_d = sel;

  // Output register; reset takes priority over the data path
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule : mux32_1

// File: tb/tb_mux32_1.sv
module tb_mux32_1;

  logic        clk;
  logic        reset_n;
  logic [31:0] din;
  logic [4:0]  ctl;
  logic        dout;

  int total = 0;
  int bad   = 0;

  logic  exp_q[$];
  string name_q[$];

  typedef struct {
    logic [31:0] in_v;
    logic [4:0]  ctl_v;
    logic        rst_v;
    logic        exp_v;
    string       name;
  } vec_t;

  vec_t tbl[8];

  mux32_1 dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in     (din),
    .control(ctl),
    .out    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare against the registered output
  task automatic check_out();
    logic  e;
    string n;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got=%b, no expected value queued", dout);
    end else begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (dout !== e) begin
        bad++;
        $display("FAIL %s: in=%h control=%0d got=%b want=%b", n, din, ctl, dout, e);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample #1 after the edge
  task automatic apply(input logic [31:0] vin, input logic [4:0] vc,
                       input logic vr, input logic vexp, input string nm);
    din     = vin;
    ctl     = vc;
    reset_n = vr;
    exp_q.push_back(vexp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [31:0] rin;
    logic [4:0]  rc;

    din = '0; ctl = '0; reset_n = 1'b0;

    tbl[0] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, "reset_edge1"};
    tbl[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, "reset_edge2"};
    tbl[2] = '{32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, "reset_release"};
    tbl[3] = '{32'hFFEF_FFFF, 5'd31, 1'b1, 1'b1, "zero20_ctl31"};
    tbl[4] = '{32'hFFEF_FFFF, 5'd20, 1'b1, 1'b0, "zero20_ctl20"};
    tbl[5] = '{32'hFFEF_FFFF, 5'd19, 1'b1, 1'b1, "zero20_ctl19"};
    tbl[6] = '{32'h0000_0001, 5'd0,  1'b1, 1'b1, "bit0_ctl0"};
    tbl[7] = '{32'h8000_0000, 5'd0,  1'b1, 1'b0, "bit31_ctl0"};

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].in_v, tbl[i].ctl_v, tbl[i].rst_v, tbl[i].exp_v, tbl[i].name);
    end

    // Walking one: out is 1 only where control matches the set bit
    for (int k = 0; k < 32; k++) begin
      for (int c = 0; c < 32; c++) begin
        apply(32'd1 << k, 5'(c), 1'b1, (c == k), "walking_one");
      end
    end

    // Simultaneous change of in and control: no glitch cycle of 0
    apply(32'h0000_0001, 5'd0,  1'b1, 1'b1, "simul_first");
    apply(32'h8000_0000, 5'd31, 1'b1, 1'b1, "simul_second");

    // Mid-stream reset for one edge, then recover
    apply(32'h0000_0004, 5'd2, 1'b1, 1'b1, "mid_before");
    apply(32'h0000_0004, 5'd2, 1'b0, 1'b0, "mid_reset");
    apply(32'h0000_0004, 5'd2, 1'b1, 1'b1, "mid_recover");

    // Random traffic checked against a bench-side bit select
    for (int t = 0; t < 1000; t++) begin
      rin = $urandom;
      rc  = 5'($urandom_range(31, 0));
      apply(rin, rc, 1'b1, rin[rc], "random");
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover: got=%0d entries want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux32_1
